// File: rtl/rs232_rcv.sv
// 8N1 serial receiver with a small byte FIFO, polled over a two-register bus
// (addr 0 = pop data, addr 1 = status / sticky-flag clear).
module rs232_rcv #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rxd,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic        i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_ack,
  output logic        o_irq
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_LD  = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(BIT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;

  state_t            r_state;
  logic              r_sync1, r_rxs;
  logic [CW-1:0]     r_bcnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_sh;
  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_fcnt;
  logic              r_ovr, r_ferr, r_ack, r_irq;
  logic [31:0]       r_dout;

  logic              w_stop_smp, w_push, w_ferr_set;
  logic              w_empty, w_full, w_rd_d, w_rd_s, w_wr_s;
  logic              w_pop, w_push_ok, w_ovr_set;
  logic [AW:0]       w_fcnt_nxt;
  logic              w_unused_din;

  assign w_unused_din = ^{i_data_in[31:4], i_data_in[1:0]};

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_bcnt  <= HALF_LD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_bcnt == '0) begin
            if (!r_rxs) begin
              r_bcnt  <= FULL_LD;
              r_bit   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bcnt <= r_bcnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_bcnt == '0) begin
            r_sh   <= {r_rxs, r_sh[7:1]};
            r_bcnt <= FULL_LD;
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_bcnt <= r_bcnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_bcnt == '0) r_state <= r_rxs ? S_IDLE : S_BRK;
          else              r_bcnt  <= r_bcnt - 1'b1;
        end
        S_BRK: begin
          // Hold off until the line returns high so a long break is one error.
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_stop_smp = (r_state == S_STOP) && (r_bcnt == '0);
  assign w_push     = w_stop_smp &  r_rxs;
  assign w_ferr_set = w_stop_smp & ~r_rxs;

  assign w_empty   = (r_fcnt == '0);
  assign w_full    = (r_fcnt == FULL_CNT);
  assign w_rd_d    = i_stb & ~i_we & ~i_addr;
  assign w_rd_s    = i_stb & ~i_we &  i_addr;
  assign w_wr_s    = i_stb &  i_we &  i_addr;
  assign w_pop     = w_rd_d & ~w_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  always_comb begin
    w_fcnt_nxt = r_fcnt;
    case ({w_push_ok, w_pop})
      2'b10:   w_fcnt_nxt = r_fcnt + 1'b1;
      2'b01:   w_fcnt_nxt = r_fcnt - 1'b1;
      default: w_fcnt_nxt = r_fcnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wp] <= r_sh;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_irq  <= 1'b0;
      r_ack  <= 1'b0;
      r_dout <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      r_fcnt <= w_fcnt_nxt;
      r_irq  <= (w_fcnt_nxt != '0);
      // Sticky flags: a set in the same cycle as a clear wins.
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_s & i_data_in[2]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_s & i_data_in[3]));
      r_ack  <= i_stb;
      if (w_rd_d) r_dout <= w_empty ? 32'd0 : {24'd0, r_mem[r_rp]};
      if (w_rd_s) r_dout <= {28'd0, r_ferr, r_ovr, w_full, ~w_empty};
    end
  end

  assign o_data_out = r_dout;
  assign o_ack      = r_ack;
  assign o_irq      = r_irq;

endmodule
